// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_master
// Description : Burst initiator for a single-port RAM with synchronous write
//               and combinational read. Accepts read/write burst commands,
//               drives the RAM pins, and streams read data out with a
//               registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  // write data channel
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  // read data channel
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  // status
  output logic                  busy_o,
  // RAM port
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state, address/count stepping and RAM/handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = addr_q;
    mem_wdata_o = wr_data_i;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          cnt_d   = cmd_len_i;
          state_d = cmd_write_i ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        wr_ready_o = 1'b1;
        // A gap in wr_valid writes nothing and leaves the address in place.
        mem_we_o   = wr_valid_i;
        if (wr_valid_i) begin
          addr_d = addr_q + c_addr_one;
          cnt_d  = cnt_q - c_len_one;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end
        end
      end

      S_READ: begin
        // Refill the output register whenever it is empty or being drained,
        // so an unstalled consumer sees one beat per clock.
        if (!rd_valid_q || rd_ready_i) begin
          rd_data_d  = mem_rdata_i;
          rd_valid_d = 1'b1;
          rd_last_d  = (cnt_q == '0);
          addr_d     = addr_q + c_addr_one;
          cnt_d      = cnt_q - c_len_one;
          if (cnt_q == '0) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (rd_valid_q && rd_ready_i) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_data_o  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_master
// Description : Self-checking bench for mem_burst_master with a behavioural
//               RAM and an expected-contents array as reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_master;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int LW    = 8;
  localparam int DEPTH = 1024;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wdata_q [$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, combinational read.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  mem_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .rd_last_o   (rd_last),
    .busy_o      (busy),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Handshake patterns: 0 always on, 1 = 1,0,1,1,0,1  2 = 1,0,0,1,0,1  3 random
  function automatic bit pat(input int mode, input int k);
    logic [5:0] wp;
    logic [5:0] rp;
    wp = 6'b101101;
    rp = 6'b101001;
    case (mode)
      0:       pat = 1'b1;
      1:       pat = wp[k % 6];
      2:       pat = rp[k % 6];
      default: pat = 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic do_write(input int addr, input int len, input int mode,
                          input bit hold, input int haddr, input int hlen);
    int beats;
    int cyc;
    int ea;
    int k;
    bit wv;
    logic [DW-1:0] d;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(addr); cmd_len = LW'(len);
    #1;
    chk("cmd_ready_idle_wr", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (hold) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(haddr); cmd_len = LW'(hlen);
    end
    beats = 0; cyc = 0; ea = addr; k = 0;
    while (beats <= len && cyc < BUDGET) begin
      wv = pat(mode, k);
      k++;
      d = (wdata_q.size() > 0) ? wdata_q[0] : DW'($urandom);
      wr_valid = wv; wr_data = d;
      #1;
      chk("wr_ready", 32'(wr_ready), 32'd1);
      chk("busy_wr", 32'(busy), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(wv));
      if (hold) chk("cmd_held_off", 32'(cmd_ready), 32'd0);
      if (wv) begin
        chk("wr_addr", 32'(mem_addr), 32'(ea));
        chk("wr_wdata", 32'(mem_wdata), 32'(d));
        ref_mem[ea] = d;
        ea = (ea + 1) % DEPTH;
        beats++;
        if (wdata_q.size() > 0) void'(wdata_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    chk("wr_beats", 32'(beats), 32'(len + 1));
    #1;
    chk("busy_after_wr", 32'(busy), 32'd0);
    chk("we_idle", 32'(mem_we), 32'd0);
  endtask

  task automatic do_read(input int addr, input int len, input int mode,
                         input int abort_at, input bit pre);
    int got;
    int cyc;
    int k;
    bit rr;
    bit stalled;
    logic [DW-1:0] sdata;
    logic slast;
    if (!pre) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(addr); cmd_len = LW'(len);
    end
    #1;
    chk("cmd_ready_idle_rd", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("rd_lat_n1", 32'(rd_valid), 32'd0);
    chk("busy_rd", 32'(busy), 32'd1);
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    got = 0; cyc = 0; k = 0; stalled = 1'b0; sdata = '0; slast = 1'b0;
    while (got <= len && cyc < BUDGET) begin
      @(negedge clk);
      rr = pat(mode, k);
      k++;
      rd_ready = rr;
      #1;
      if (cyc == 0) chk("rd_lat_n2", 32'(rd_valid), 32'd1);
      chk("we_rd", 32'(mem_we), 32'd0);
      if (stalled) begin
        chk("stall_valid", 32'(rd_valid), 32'd1);
        chk("stall_data", 32'(rd_data), 32'(sdata));
        chk("stall_last", 32'(rd_last), 32'(slast));
      end
      stalled = 1'b0;
      if (rd_valid) begin
        if (rr) begin
          chk("rd_data", 32'(rd_data), 32'(ref_mem[(addr + got) % DEPTH]));
          chk("rd_last", 32'(rd_last), 32'(got == len));
          got++;
        end else begin
          stalled = 1'b1; sdata = rd_data; slast = rd_last;
        end
      end
      cyc++;
      if (abort_at >= 0 && got == abort_at) break;
    end
    if (abort_at >= 0) begin
      chk("abort_beats", 32'(got), 32'(abort_at));
      @(posedge clk);
      #2;
      chk("pre_rst_valid", 32'(rd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rd_last", 32'(rd_last), 32'd0);
      @(negedge clk);
      rd_ready = 1'b0;
      rst_n = 1'b1;
    end else begin
      chk("rd_beats", 32'(got), 32'(len + 1));
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      chk("rd_valid_end", 32'(rd_valid), 32'd0);
      chk("busy_end", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int l;
    int m;
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole RAM with maximum-length bursts.
    for (int b = 0; b < 4; b++) do_write(b * 256, 255, 0, 1'b0, 0, 0);

    // Write then read back 0x010..0x013.
    wdata_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(16, 3, 0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) chk("ram_a0", 32'(ram[16 + i]), 32'(8'hA0 + i));
    do_read(16, 3, 0, -1, 1'b0);

    // Burst across the top of the address space.
    wdata_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(1022, 3, 0, 1'b0, 0, 0);
    chk("wrap_3fe", 32'(ram[1022]), 32'h11);
    chk("wrap_3ff", 32'(ram[1023]), 32'h22);
    chk("wrap_000", 32'(ram[0]), 32'h33);
    chk("wrap_001", 32'(ram[1]), 32'h44);
    do_read(1022, 3, 0, -1, 1'b0);

    // Read with consumer stalls, write with producer gaps.
    do_read(100, 7, 2, -1, 1'b0);
    do_write(200, 3, 1, 1'b0, 0, 0);
    do_read(200, 3, 0, -1, 1'b0);

    // Command presented during a running burst is held, then executed.
    do_write(300, 5, 3, 1'b1, 300, 5);
    do_read(300, 5, 0, -1, 1'b1);

    // Reset in the middle of a read, then a clean read.
    do_read(400, 7, 0, 2, 1'b0);
    do_read(400, 7, 0, -1, 1'b0);

    // Randomized traffic.
    repeat (30) begin
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      m = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) do_write(a, l, (m == 2) ? 1 : m, 1'b0, 0, 0);
      else                           do_read(a, l, (m == 1) ? 2 : m, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
